// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// A grant is held for a whole packet (up to req_last) so messages never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_timeout_pulse
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t             r_state, w_nextState;
  logic [NUM_REQ-1:0] r_grant, w_nextGrant;
  logic [PTR_W-1:0]   r_rrPtr, w_nextRrPtr;
  logic [TMR_W-1:0]   r_timer, w_nextTimer;
  logic               r_timeoutPulse, w_nextPulse;

  logic                  w_ownerValid;
  logic                  w_ownerLast;
  logic                  w_transfer;
  logic [PTR_W-1:0]      w_ownerIdx;
  logic [PTR_W-1:0]      w_winnerIdx;
  logic                  w_found;
  logic [PTR_W:0]        w_sum;
  logic [PTR_W-1:0]      w_cand;
  logic [DATA_WIDTH-1:0] w_ownerData;

  assign w_ownerValid = |(i_req_valid & r_grant);
  assign w_ownerLast  = |(i_req_last & r_grant);
  assign w_transfer   = w_ownerValid & i_tx_ready;

  // Grant is one-hot, so an AND-OR mux and a priority-free encode are sufficient.
  always_comb begin
    w_ownerIdx  = '0;
    w_ownerData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_ownerIdx  = PTR_W'(i);
        w_ownerData = w_ownerData | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Scan rrPtr+1, rrPtr+2, ... wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_winnerIdx = r_rrPtr;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_rrPtr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && i_req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_winnerIdx = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_rrPtr        <= PTR_INIT;
      r_timer        <= '0;
      r_timeoutPulse <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_grant        <= w_nextGrant;
      r_rrPtr        <= w_nextRrPtr;
      r_timer        <= w_nextTimer;
      r_timeoutPulse <= w_nextPulse;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextRrPtr = r_rrPtr;
    w_nextTimer = r_timer;
    w_nextPulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nextState              = ST_OWNED;
          w_nextGrant              = '0;
          w_nextGrant[w_winnerIdx] = 1'b1;
          w_nextTimer              = '0;
        end
      end
      ST_OWNED: begin
        if (w_transfer) begin
          w_nextTimer = '0;
          if (w_ownerLast) begin
            w_nextState = ST_IDLE;
            w_nextGrant = '0;
            w_nextRrPtr = w_ownerIdx;
          end
        end else if (TIMEOUT_CYCLES != 0 && !w_ownerValid) begin
          // A stalled transmitter never counts; only a silent owner does.
          if (r_timer == TMR_LAST) begin
            w_nextState = ST_IDLE;
            w_nextGrant = '0;
            w_nextRrPtr = w_ownerIdx;
            w_nextTimer = '0;
            w_nextPulse = 1'b1;
          end else if (r_timer != '1) begin
            w_nextTimer = r_timer + TMR_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    if (r_state == ST_OWNED) begin
      o_tx_valid  = w_ownerValid;
      o_tx_data   = w_ownerData;
      o_req_ready = r_grant & {NUM_REQ{i_tx_ready}};
    end
  end

  assign o_grant         = r_grant;
  assign o_timeout_pulse = r_timeoutPulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level reference model predicts every
// transfer, grant and timeout; a monitor compares them against the DUT each cycle.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int TC   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ-1:0] reqValid;
  logic [NREQ-1:0] reqLast;
  logic [NREQ-1:0] reqReady;
  logic [DW-1:0]   txData;
  logic            txValid;
  logic            txReady;
  logic [NREQ-1:0] grant;
  logic            timeoutPulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (NREQ),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_data     (reqData),
    .i_req_valid    (reqValid),
    .i_req_last     (reqLast),
    .o_req_ready    (reqReady),
    .o_tx_data      (txData),
    .o_tx_valid     (txValid),
    .i_tx_ready     (txReady),
    .o_grant        (grant),
    .o_timeout_pulse(timeoutPulse)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  logic [8:0] srcQ0[$];
  logic [8:0] srcQ1[$];
  int         rd[2];
  int         gapCnt[2];
  int         readyMode = 1;
  bit         gapEn = 1'b0;
  int         holdSeq = 0;
  int         holdLen = 0;
  bit         checkEn = 1'b0;

  int         mOwner = -1;
  int         mPtr = NREQ - 1;
  int         mTimer = 0;
  bit         mPulse = 1'b0;
  int         expTimeouts = 0;
  logic [1:0] expGrantNow = '0;
  logic       expTxValidNow = 1'b0;
  logic       expPulseNow = 1'b0;
  logic [8:0] expQ[$];
  int         xferLog[$];
  int         pulseCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Queue one packet of len bytes (LSB byte first); last flag rides on the final byte.
  task automatic applyStimulus(input int idx, input int len, input logic [31:0] bytes);
    for (int b = 0; b < len; b++) begin
      logic [8:0] e;
      e = {(b == len - 1), bytes[b*8 +: 8]};
      if (idx == 0) srcQ0.push_back(e);
      else          srcQ1.push_back(e);
    end
  endtask

  function automatic int pending(input int idx);
    return (idx == 0) ? (srcQ0.size() - rd[0]) : (srcQ1.size() - rd[1]);
  endfunction

  function automatic int logAt(input int k);
    return (k < xferLog.size()) ? xferLog[k] : -1;
  endfunction

  task automatic driverLoop();
    bit acc[2];
    int lastHoldSeq = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) acc[i] = reqValid[i] && reqReady[i] && !rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          rd[i]++;
          if (i == 0 && holdSeq != lastHoldSeq) begin
            gapCnt[0]   = holdLen;
            lastHoldSeq = holdSeq;
          end else if (gapEn && $urandom_range(0, 3) == 0) begin
            gapCnt[i] = $urandom_range(1, 3);
          end
        end
        if (gapCnt[i] > 0) begin
          gapCnt[i]--;
          reqValid[i] = 1'b0;
          reqLast[i]  = 1'b0;
        end else if (pending(i) > 0) begin
          e = (i == 0) ? srcQ0[rd[0]] : srcQ1[rd[1]];
          reqValid[i]        = 1'b1;
          reqLast[i]         = e[8];
          reqData[i*DW +: DW] = e[7:0];
        end else begin
          reqValid[i] = 1'b0;
          reqLast[i]  = 1'b0;
        end
      end
      case (readyMode)
        0:       txReady = ($urandom_range(0, 3) != 0);
        2:       txReady = 1'b0;
        default: txReady = 1'b1;
      endcase
    end
  endtask

  // Packet-level model: who owns the line, which byte moves, when silence forces a release.
  task automatic modelLoop();
    int g;
    int c;
    forever begin
      @(negedge clk);
      expGrantNow   = (mOwner >= 0) ? (2'b01 << mOwner) : 2'b00;
      expTxValidNow = (mOwner >= 0) ? reqValid[mOwner] : 1'b0;
      expPulseNow   = mPulse;
      mPulse        = 1'b0;
      if (rst) begin
        mOwner = -1;
        mPtr   = NREQ - 1;
        mTimer = 0;
      end else if (mOwner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (mPtr + k) % NREQ;
          if (mOwner < 0 && reqValid[c]) begin
            mOwner = c;
            mTimer = 0;
          end
        end
      end else begin
        g = mOwner;
        if (reqValid[g] && txReady) begin
          expQ.push_back({g[0], reqData[g*DW +: DW]});
          mTimer = 0;
          if (reqLast[g]) begin
            mOwner = -1;
            mPtr   = g;
          end
        end else if (!reqValid[g]) begin
          if (mTimer == TC - 1) begin
            mOwner = -1;
            mPtr   = g;
            mTimer = 0;
            mPulse = 1'b1;
            expTimeouts++;
          end else begin
            mTimer++;
          end
        end
      end
    end
  endtask

  task automatic monitorLoop();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (checkEn) begin
        checkOutput("grant", 32'(grant), 32'(expGrantNow));
        checkOutput("txValid", 32'(txValid), 32'(expTxValidNow));
        checkOutput("reqReady", 32'(reqReady), 32'(expGrantNow & {NREQ{txReady}}));
        checkOutput("timeoutPulse", 32'(timeoutPulse), 32'(expPulseNow));
        if (timeoutPulse) pulseCount++;
        if (!rst && txValid && txReady) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedTransfer", 32'(txData), 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("txData", 32'(txData), 32'(e[7:0]));
            checkOutput("xferOwner", 32'(grant), e[8] ? 32'h2 : 32'h1);
          end
          xferLog.push_back(grant[1] ? 1 : 0);
        end
      end
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((pending(0) > 0 || pending(1) > 0 || mOwner >= 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drainWithinBudget", 32'(n < budget), 32'h1);
    repeat (3) @(posedge clk);
  endtask

  task automatic waitAccepted(input int idx, input int target, input int budget);
    int n = 0;
    while (rd[idx] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("acceptWithinBudget", 32'(n < budget), 32'h1);
  endtask

  initial begin
    int base;
    int p0;
    rst      = 1'b1;
    reqValid = '0;
    reqLast  = '0;
    reqData  = '0;
    txReady  = 1'b1;
    rd[0] = 0; rd[1] = 0;
    gapCnt[0] = 0; gapCnt[1] = 0;
    fork
      driverLoop();
      modelLoop();
      monitorLoop();
    join_none

    // Reset with both requesters presenting bytes: nothing may leak out.
    applyStimulus(0, 3, 32'h00310a0d);
    applyStimulus(1, 1, 32'h00000055);
    @(posedge clk);
    #1 checkEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      checkOutput("resetGrant", 32'(grant), 32'h0);
      checkOutput("resetTxValid", 32'(txValid), 32'h0);
      checkOutput("resetReqReady", 32'(reqReady), 32'h0);
    end
    rst = 1'b0;
    $display("[TB] single packet after reset");
    waitDrain(200);
    checkOutput("singleOrder0", 32'(logAt(0)), 32'h0);
    checkOutput("singleOrder2", 32'(logAt(2)), 32'h0);
    checkOutput("singleThenReq1", 32'(logAt(3)), 32'h1);

    $display("[TB] contention");
    base = xferLog.size();
    applyStimulus(0, 2, 32'h00006261);
    applyStimulus(1, 2, 32'h00006463);
    waitDrain(200);
    checkOutput("contentionCount", 32'(xferLog.size() - base), 32'd4);
    checkOutput("contentionFirst", 32'(logAt(base)), 32'h0);
    checkOutput("contentionNoInterleave", 32'(logAt(base + 1)), 32'h0);
    checkOutput("contentionSecond", 32'(logAt(base + 2)), 32'h1);
    checkOutput("contentionSecondTail", 32'(logAt(base + 3)), 32'h1);

    $display("[TB] fairness");
    base = xferLog.size();
    for (int p = 0; p < 4; p++) begin
      applyStimulus(0, 1, $urandom());
      applyStimulus(1, 1, $urandom());
    end
    waitDrain(300);
    for (int k = 0; k < 8; k++) checkOutput("fairAlternate", 32'(logAt(base + k)), 32'(k % 2));

    $display("[TB] backpressure");
    p0 = pulseCount;
    applyStimulus(0, 4, $urandom());
    waitAccepted(0, srcQ0.size() - 2, 100);
    readyMode = 2;
    repeat (500) @(posedge clk);
    #2;
    checkOutput("stallGrantHeld", 32'(grant), 32'h1);
    checkOutput("stallValidHeld", 32'(txValid), 32'h1);
    checkOutput("stallNoTimeout", 32'(pulseCount - p0), 32'h0);
    readyMode = 1;
    waitDrain(200);

    $display("[TB] timeout");
    p0   = pulseCount;
    base = xferLog.size();
    holdLen = 40;
    holdSeq++;
    applyStimulus(0, 3, 32'h00737271);
    waitAccepted(0, srcQ0.size() - 2, 100);
    applyStimulus(1, 1, 32'h00000078);
    waitDrain(400);
    checkOutput("timeoutOnce", 32'(pulseCount - p0), 32'h1);
    checkOutput("timeoutFirst", 32'(logAt(base)), 32'h0);
    checkOutput("timeoutHandover", 32'(logAt(base + 1)), 32'h1);
    checkOutput("timeoutResume", 32'(logAt(base + 2)), 32'h0);

    $display("[TB] reset mid-packet");
    applyStimulus(0, 4, $urandom());
    waitAccepted(0, srcQ0.size() - 3, 100);
    readyMode = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("grantAfterReset", 32'(grant), 32'h0);
    checkOutput("txValidAfterReset", 32'(txValid), 32'h0);
    readyMode = 1;
    waitDrain(200);

    $display("[TB] randomized traffic");
    gapEn     = 1'b1;
    readyMode = 0;
    for (int p = 0; p < 40; p++) begin
      applyStimulus(0, $urandom_range(1, 4), $urandom());
      applyStimulus(1, $urandom_range(1, 4), $urandom());
    end
    waitDrain(8000);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);
    checkOutput("timeoutTotal", 32'(pulseCount), 32'(expTimeouts));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
